// File: rtl/systolic_skew_buffer.sv
// Per-lane skew/deskew delay stage with valid tracking, stall and tile drain FSM.
// Optional build macro SYSTOLIC_SKEW_ZERO_GATE_EN forces invalid lanes to zero.
module systolic_skew_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SA_LENGTH  = 16
) (
  input  logic                         CLK,
  input  logic                         ASYNC_RST,
  input  logic                         SYNC_RST,
  input  logic                         MODE,
  input  logic                         STALL,
  input  logic                         IN_VALID,
  input  logic                         IN_LAST,
  output logic                         IN_READY,
  input  logic signed [DATA_WIDTH-1:0] Inputs  [SA_LENGTH],
  output logic signed [DATA_WIDTH-1:0] Outputs [SA_LENGTH],
  output logic        [SA_LENGTH-1:0]  OUT_VALID,
  output logic                         BUSY,
  output logic                         DONE
);

  localparam int unsigned CW     = $clog2(SA_LENGTH) + 1;
  localparam bit          SINGLE = (SA_LENGTH == 1);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          ready_c;
  logic          accept;
  logic          mode_sel;

  assign ready_c  = (state_q != DRAIN) && !STALL;
  assign accept   = IN_VALID && ready_c;
  // The first vector of a tile must already see its own mode on the taps.
  assign mode_sel = ((state_q == IDLE) && accept) ? MODE : mode_q;

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else if (SYNC_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else if (!STALL) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (state_q == IDLE) mode_d = MODE;
          if (IN_LAST) begin
            state_d = SINGLE ? IDLE : DRAIN;
            cnt_d   = CW'(SA_LENGTH - 1);
          end else begin
            state_d = STREAM;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    IN_READY = ready_c;
    BUSY     = (state_q != IDLE);
    DONE     = 1'b0;
    if (SINGLE) DONE = accept && IN_LAST;
    else        DONE = (state_q == DRAIN) && (cnt_q == CW'(1)) && !STALL;
  end

  for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
    localparam int unsigned D_SK = i;
    localparam int unsigned D_DS = SA_LENGTH - 1 - i;
    localparam int unsigned CL   = (D_SK > D_DS) ? D_SK : D_DS;

    logic signed [DATA_WIDTH-1:0] tap_data;
    logic                         tap_vld;

    if (CL > 0) begin : g_chain
      localparam int unsigned IW = (CL > 1) ? $clog2(CL) : 1;

      // Chain is only as deep as the longer of this lane's two delays.
      logic signed [DATA_WIDTH-1:0] sr_data [CL];
      logic                         sr_vld  [CL];
      logic [IW-1:0]                tap_idx;
      logic                         pass;

      always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
          for (int k = 0; k < CL; k++) begin
            sr_data[k] <= '0;
            sr_vld[k]  <= 1'b0;
          end
        end else if (SYNC_RST) begin
          for (int k = 0; k < CL; k++) begin
            sr_data[k] <= '0;
            sr_vld[k]  <= 1'b0;
          end
        end else if (!STALL) begin
          sr_data[0] <= accept ? Inputs[i] : '0;
          sr_vld[0]  <= accept;
          for (int k = 1; k < CL; k++) begin
            sr_data[k] <= sr_data[k-1];
            sr_vld[k]  <= sr_vld[k-1];
          end
        end
      end

      always_comb begin
        tap_idx = '0;
        pass    = 1'b0;
        if (mode_sel) begin
          if (D_DS == 0) pass = 1'b1;
          else           tap_idx = IW'(D_DS - 1);
        end else begin
          if (D_SK == 0) pass = 1'b1;
          else           tap_idx = IW'(D_SK - 1);
        end
        tap_data = pass ? Inputs[i] : sr_data[tap_idx];
        tap_vld  = pass ? accept    : sr_vld[tap_idx];
      end
    end else begin : g_pass
      assign tap_data = Inputs[i];
      assign tap_vld  = accept;
    end

    assign OUT_VALID[i] = tap_vld && !STALL;

`ifdef SYSTOLIC_SKEW_ZERO_GATE_EN
    assign Outputs[i] = OUT_VALID[i] ? tap_data : '0;
`else
    // Holds the last presented value so pass-through lanes stay frozen under stall.
    logic signed [DATA_WIDTH-1:0] hold_q;

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
      if (ASYNC_RST)   hold_q <= '0;
      else if (SYNC_RST) hold_q <= '0;
      else if (!STALL) hold_q <= tap_data;
    end

    assign Outputs[i] = STALL ? hold_q : tap_data;
`endif
  end

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Scoreboard bench for systolic_skew_buffer (SA_LENGTH=4, DATA_WIDTH=8).
`timescale 1ns/1ps
module tb_systolic_skew_buffer;

  localparam int NL = 4;
  localparam int DW = 8;

  logic CLK = 1'b0;
  logic ASYNC_RST, SYNC_RST, MODE, STALL, IN_VALID, IN_LAST;
  logic IN_READY, BUSY, DONE;
  logic signed [DW-1:0] din  [NL];
  logic signed [DW-1:0] dout [NL];
  logic [NL-1:0] OUT_VALID;

  always #5 CLK = ~CLK;

  systolic_skew_buffer #(.DATA_WIDTH(DW), .SA_LENGTH(NL)) dut (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .MODE(MODE),
    .STALL(STALL), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .IN_READY(IN_READY),
    .Inputs(din), .Outputs(dout), .OUT_VALID(OUT_VALID), .BUSY(BUSY), .DONE(DONE)
  );

  typedef struct {int due; int data;} exp_t;

  exp_t lane_q [NL][$];
  int   done_q [$];
  int   ns;
  bit   m_busy, m_drain, m_mode;
  int   last_exp   [NL];
  bit   last_known [NL];
  int   n_checks, n_fail;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) begin
      lane_q[i].delete();
      last_known[i] = 1'b0;
    end
    done_q.delete();
    m_busy = 1'b0; m_drain = 1'b0; m_mode = 1'b0;
  endtask

  // One clock: push expectations for this cycle's accept, compare, advance model.
  task automatic tick();
    bit rdy, acc, eff_mode, exp_v, exp_done;
    int d;
    #1;
    rdy = !m_drain && !STALL;
    acc = IN_VALID && rdy;
    check_eq("in_ready", int'(IN_READY), int'(rdy));
    check_eq("busy", int'(BUSY), int'(m_busy));
    if (acc) begin
      eff_mode = m_busy ? m_mode : MODE;
      for (int i = 0; i < NL; i++) begin
        d = eff_mode ? NL - 1 - i : i;
        lane_q[i].push_back('{ns + d, int'(din[i])});
      end
      if (IN_LAST) done_q.push_back(ns + NL - 1);
    end
    for (int i = 0; i < NL; i++) begin
      exp_v = !STALL && (lane_q[i].size() > 0) && (lane_q[i][0].due == ns);
      check_eq($sformatf("lane%0d_valid@%0d", i, ns), int'(OUT_VALID[i]), int'(exp_v));
      if (exp_v) begin
        check_eq($sformatf("lane%0d_data@%0d", i, ns), int'(dout[i]), lane_q[i][0].data);
        last_exp[i]   = lane_q[i][0].data;
        last_known[i] = 1'b1;
        void'(lane_q[i].pop_front());
      end else begin
`ifdef SYSTOLIC_SKEW_ZERO_GATE_EN
        check_eq($sformatf("lane%0d_gated@%0d", i, ns), int'(dout[i]), 0);
`else
        if (STALL && last_known[i])
          check_eq($sformatf("lane%0d_hold@%0d", i, ns), int'(dout[i]), last_exp[i]);
        else if (!STALL)
          last_known[i] = 1'b0;
`endif
      end
    end
    exp_done = !STALL && (done_q.size() > 0) && (done_q[0] == ns);
    check_eq($sformatf("done@%0d", ns), int'(DONE), int'(exp_done));
    if (exp_done) void'(done_q.pop_front());
    @(posedge CLK);
    if (SYNC_RST) begin
      model_clear();
    end else if (!STALL) begin
      if (acc) begin
        if (!m_busy) m_mode = MODE;
        m_busy = 1'b1;
        if (IN_LAST) m_drain = 1'b1;
      end
      if (exp_done) begin
        m_busy  = 1'b0;
        m_drain = 1'b0;
      end
      ns++;
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit l, input bit m, input bit s,
                       input int a, input int b, input int c, input int e);
    IN_VALID = v; IN_LAST = l; MODE = m; STALL = s;
    din[0] = DW'(a); din[1] = DW'(b); din[2] = DW'(c); din[3] = DW'(e);
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_fail = 0; ns = 0;
    model_clear();
    ASYNC_RST = 1'b1; SYNC_RST = 1'b0; MODE = 1'b0; STALL = 1'b0;
    IN_VALID = 1'b0; IN_LAST = 1'b0;
    for (int i = 0; i < NL; i++) din[i] = '0;
    repeat (2) @(posedge CLK);
    #1 ASYNC_RST = 1'b0;
    #1;
    check_eq("rst_busy", int'(BUSY), 0);
    check_eq("rst_done", int'(DONE), 0);
    check_eq("rst_in_ready", int'(IN_READY), 1);
    check_eq("rst_out_valid", int'(OUT_VALID), 0);
    for (int i = 1; i < NL; i++) check_eq($sformatf("rst_lane%0d", i), int'(dout[i]), 0);

    // Skew tile of two vectors
    drive(1, 0, 0, 0, 1, 2, 3, 4);
    drive(1, 1, 0, 0, 5, 6, 7, 8);
    idle(6);

    // Deskew single-vector tile
    drive(1, 1, 1, 0, -1, -2, -3, -4);
    idle(5);

    // Stall for two cycles in drain, with valid held high
    drive(1, 0, 0, 0, 10, 20, 30, 40);
    drive(1, 1, 0, 0, 11, 21, 31, 41);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 99, 99, 99, 99);
    drive(1, 0, 0, 1, 99, 99, 99, 99);
    idle(6);

    // MODE flips mid-tile; tile stays skewed
    drive(1, 0, 0, 0, 100, 101, 102, 103);
    drive(1, 0, 1, 0, -100, -101, -102, -103);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 127, -128, 64, -65);
    idle(6);

    // Random traffic: gaps, stalls, mode toggles, extreme values
    for (int k = 0; k < 80; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
            int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    end
    drive(1, 1, 0, 0, 7, 7, 7, 7);
    idle(6);

    // Async reset during drain aborts the tile
    drive(1, 0, 0, 0, 1, 1, 1, 1);
    drive(1, 1, 0, 0, 2, 2, 2, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    ASYNC_RST = 1'b1;
    #1;
    for (int i = 0; i < NL; i++) check_eq($sformatf("arst_lane%0d", i), int'(dout[i]), 0);
    check_eq("arst_out_valid", int'(OUT_VALID), 0);
    check_eq("arst_busy", int'(BUSY), 0);
    check_eq("arst_done", int'(DONE), 0);
    model_clear();
    @(posedge CLK);
    #1 ASYNC_RST = 1'b0;
    idle(5);

    // Sync reset together with stall still clears at the edge
    drive(1, 0, 0, 0, 3, 3, 3, 3);
    drive(1, 1, 0, 0, 4, 4, 4, 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    SYNC_RST = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    SYNC_RST = 1'b0;
    for (int i = 0; i < NL; i++) check_eq($sformatf("srst_lane%0d", i), int'(dout[i]), 0);
    check_eq("srst_busy", int'(BUSY), 0);
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
